// File: rtl/mem_stage_sram_ctrl.sv
// Memory-stage controller: splits each 32-bit load/store into two half-word
// accesses on a 16-bit asynchronous SRAM and freezes the pipeline meanwhile.
module mem_stage_sram_ctrl #(
  parameter int          WAIT_CYCLES = 2,
  parameter logic [31:0] DATA_BASE   = 32'd1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MEM_R_En,
  input  logic        MEM_W_En,
  input  logic [31:0] ALU_result,
  input  logic [31:0] readdata,
  output logic [31:0] mem_read_data,
  output logic        freeze,
  output logic [17:0] SRAM_ADDR,
  output logic [15:0] SRAM_DQ_out,
  input  logic [15:0] SRAM_DQ_in,
  output logic        SRAM_DQ_oe,
  output logic        SRAM_WE_N,
  output logic        SRAM_OE_N
);

  typedef enum logic [2:0] {IDLE, RD_LO, RD_HI, WR_LO, WR_HI, DONE} state_t;

  localparam logic [3:0] LAST = 4'(WAIT_CYCLES - 1);

  state_t      state, state_nxt;
  logic [3:0]  cnt;
  logic [16:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] eff;
  logic        last;
  logic        unused_bits;

  // Word index inside data memory; byte offset bits are deliberately dropped.
  assign eff         = ALU_result - DATA_BASE;
  assign last        = (cnt == LAST);
  assign unused_bits = ^{eff[31:19], eff[1:0]};

  // Next state: write wins over read; DONE ignores enables so the finished
  // instruction is not reissued while the pipeline advances.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (MEM_W_En) state_nxt = WR_LO;
               else if (MEM_R_En) state_nxt = RD_LO;
      RD_LO:   if (last) state_nxt = RD_HI;
      RD_HI:   if (last) state_nxt = DONE;
      WR_LO:   if (last) state_nxt = WR_HI;
      WR_HI:   if (last) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // SRAM strobes and freeze; WE rises on the last cycle of a write half so
  // address and data stay valid across the rising edge.
  always_comb begin
    freeze      = 1'b0;
    SRAM_OE_N   = 1'b1;
    SRAM_WE_N   = 1'b1;
    SRAM_DQ_oe  = 1'b0;
    SRAM_DQ_out = 16'h0;
    SRAM_ADDR   = {addr_q, 1'b0};
    case (state)
      IDLE:  freeze = MEM_R_En | MEM_W_En;
      RD_LO: begin
        freeze    = 1'b1;
        SRAM_OE_N = 1'b0;
      end
      RD_HI: begin
        freeze    = 1'b1;
        SRAM_OE_N = 1'b0;
        SRAM_ADDR = {addr_q, 1'b1};
      end
      WR_LO: begin
        freeze      = 1'b1;
        SRAM_DQ_oe  = 1'b1;
        SRAM_DQ_out = wdata_q[15:0];
        SRAM_WE_N   = last;
      end
      WR_HI: begin
        freeze      = 1'b1;
        SRAM_DQ_oe  = 1'b1;
        SRAM_DQ_out = wdata_q[31:16];
        SRAM_WE_N   = last;
        SRAM_ADDR   = {addr_q, 1'b1};
      end
      default: ;
    endcase
  end

  // State, wait counter, request latches and load-word assembly.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      cnt           <= 4'd0;
      addr_q        <= 17'd0;
      wdata_q       <= 32'd0;
      mem_read_data <= 32'd0;
    end else begin
      state <= state_nxt;
      if (state_nxt != state || state == IDLE || state == DONE)
        cnt <= 4'd0;
      else
        cnt <= cnt + 4'd1;
      if (state == IDLE && (MEM_W_En || MEM_R_En))
        addr_q <= eff[18:2];
      if (state == IDLE && MEM_W_En)
        wdata_q <= readdata;
      if (state == RD_LO && last)
        mem_read_data[15:0] <= SRAM_DQ_in;
      if (state == RD_HI && last)
        mem_read_data[31:16] <= SRAM_DQ_in;
    end
  end

endmodule

// File: tb/tb_mem_stage_sram_ctrl.sv
// Directed bench: two controllers (WAIT_CYCLES 2 and 4), each on its own
// small SRAM model, exercised with hand-computed transactions.
module tb_mem_stage_sram_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1;

  logic        r2 = 0, w2 = 0, r4 = 0, w4 = 0;
  logic [31:0] a2 = 0, d2 = 0, a4 = 0, d4 = 0;
  logic [31:0] mrd2, mrd4;
  logic        frz2, frz4, dqoe2, dqoe4, we2, we4, oe2, oe4;
  logic [17:0] ad2, ad4;
  logic [15:0] do2, do4, di2, di4;

  logic [15:0] mem2 [0:63];
  logic [15:0] mem4 [0:63];
  logic        pk2 = 0, pk4 = 0;
  logic [5:0]  pk_a = 0;
  logic [15:0] pk_d = 0;

  mem_stage_sram_ctrl #(.WAIT_CYCLES(2), .DATA_BASE(32'd1024)) dut2 (
    .clk(clk), .rst(rst), .MEM_R_En(r2), .MEM_W_En(w2), .ALU_result(a2),
    .readdata(d2), .mem_read_data(mrd2), .freeze(frz2), .SRAM_ADDR(ad2),
    .SRAM_DQ_out(do2), .SRAM_DQ_in(di2), .SRAM_DQ_oe(dqoe2),
    .SRAM_WE_N(we2), .SRAM_OE_N(oe2));

  mem_stage_sram_ctrl #(.WAIT_CYCLES(4), .DATA_BASE(32'd1024)) dut4 (
    .clk(clk), .rst(rst), .MEM_R_En(r4), .MEM_W_En(w4), .ALU_result(a4),
    .readdata(d4), .mem_read_data(mrd4), .freeze(frz4), .SRAM_ADDR(ad4),
    .SRAM_DQ_out(do4), .SRAM_DQ_in(di4), .SRAM_DQ_oe(dqoe4),
    .SRAM_WE_N(we4), .SRAM_OE_N(oe4));

  // SRAM models: write while WE low with pads driven, read when OE low.
  always @(posedge clk) begin
    if (pk2) mem2[pk_a] <= pk_d;
    else if (!we2 && dqoe2) mem2[ad2[5:0]] <= do2;
    if (pk4) mem4[pk_a] <= pk_d;
    else if (!we4 && dqoe4) mem4[ad4[5:0]] <= do4;
  end
  assign di2 = oe2 ? 16'h0 : mem2[ad2[5:0]];
  assign di4 = oe4 ? 16'h0 : mem4[ad4[5:0]];

  logic sel = 1'b0;
  wire        m_frz  = sel ? frz4  : frz2;
  wire        m_we   = sel ? we4   : we2;
  wire        m_oe   = sel ? oe4   : oe2;
  wire        m_dqoe = sel ? dqoe4 : dqoe2;
  wire [31:0] m_mrd  = sel ? mrd4  : mrd2;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic poke(input bit s, input logic [5:0] a, input logic [15:0] d);
    @(posedge clk); #1;
    pk_a = a; pk_d = d; pk2 = !s; pk4 = s;
    @(posedge clk); #1;
    pk2 = 0; pk4 = 0;
  endtask

  task automatic idle();
    @(posedge clk); #1;
    r2 = 0; w2 = 0; r4 = 0; w4 = 0;
  endtask

  // Drive one request in an IDLE cycle and count frozen/strobe cycles until
  // the first unfrozen (DONE) cycle, where it returns.
  task automatic access(input bit s, input logic r, input logic w,
                        input logic [31:0] a, input logic [31:0] d,
                        output int nf, output int nwe, output int noe,
                        output int ndq, output int lo_at);
    logic [15:0] lo0;
    nf = 0; nwe = 0; noe = 0; ndq = 0; lo_at = 0;
    @(posedge clk); #1;
    sel = s;
    if (s) begin r4 = r; w4 = w; a4 = a; d4 = d; end
    else   begin r2 = r; w2 = w; a2 = a; d2 = d; end
    #1;
    lo0 = m_mrd[15:0];
    while (m_frz && nf < 40) begin
      nf++;
      if (!m_we) nwe++;
      if (m_dqoe) ndq++;
      if (!m_oe) begin
        noe++;
        if (lo_at == 0 && m_mrd[15:0] != lo0) lo_at = noe;
      end
      @(posedge clk); #2;
    end
  endtask

  int nf, nwe, noe, ndq, lo_at;

  initial begin
    repeat (2) @(posedge clk);
    #2;
    chk("rst_mrd",   mrd2, 32'h0);
    chk("rst_frz",   {31'b0, frz2}, 32'h0);
    chk("rst_we_n",  {31'b0, we2}, 32'h1);
    chk("rst_oe_n",  {31'b0, oe2}, 32'h1);
    chk("rst_dq_oe", {31'b0, dqoe2}, 32'h0);
    chk("rst_addr",  {14'b0, ad2}, 32'h0);
    chk("rst_dqout", {16'b0, do2}, 32'h0);
    for (int i = 0; i < 64; i++) poke(0, 6'(i), 16'h0);
    for (int i = 0; i < 8; i++) poke(1, 6'(i), 16'h0);
    poke(0, 6'd4, 16'hCAFE);
    poke(0, 6'd5, 16'hF00D);
    poke(1, 6'd6, 16'h3C3C);
    poke(1, 6'd7, 16'h7E7E);
    @(posedge clk); #1; rst = 0;

    // Store 0xDEADBEEF to 1028 -> half addresses 2/3
    access(0, 0, 1, 32'd1028, 32'hDEADBEEF, nf, nwe, noe, ndq, lo_at);
    chk("st_freeze", 32'(nf), 32'd5);
    chk("st_we_low", 32'(nwe), 32'd2);
    chk("st_dq_oe",  32'(ndq), 32'd4);
    chk("st_oe_low", 32'(noe), 32'd0);
    chk("st_done",   {31'b0, frz2}, 32'h0);
    chk("st_mrd",    mrd2, 32'h0);
    idle();
    chk("st_mem2",   {16'b0, mem2[2]}, 32'h0000BEEF);
    chk("st_mem3",   {16'b0, mem2[3]}, 32'h0000DEAD);

    // Load back from 1028
    access(0, 1, 0, 32'd1028, 32'h0, nf, nwe, noe, ndq, lo_at);
    chk("ld_freeze", 32'(nf), 32'd5);
    chk("ld_oe_low", 32'(noe), 32'd4);
    chk("ld_dq_oe",  32'(ndq), 32'd0);
    chk("ld_mrd",    mrd2, 32'hDEADBEEF);
    idle();

    // Back-to-back: store to 1024 (enables held through DONE), then load 1032
    access(0, 0, 1, 32'd1024, 32'h12345678, nf, nwe, noe, ndq, lo_at);
    chk("b2b_st_freeze", 32'(nf), 32'd5);
    chk("b2b_st_we",     32'(nwe), 32'd2);
    access(0, 1, 0, 32'd1032, 32'h0, nf, nwe, noe, ndq, lo_at);
    chk("b2b_ld_freeze", 32'(nf), 32'd5);
    chk("b2b_ld_we",     32'(nwe), 32'd0);
    chk("b2b_ld_oe",     32'(noe), 32'd4);
    chk("b2b_ld_mrd",    mrd2, 32'hF00DCAFE);
    idle();
    chk("b2b_mem0", {16'b0, mem2[0]}, 32'h00005678);
    chk("b2b_mem1", {16'b0, mem2[1]}, 32'h00001234);

    // Both enables: acts as a write, load word untouched
    access(0, 1, 1, 32'd1032, 32'hA5A55A5A, nf, nwe, noe, ndq, lo_at);
    chk("both_oe",  32'(noe), 32'd0);
    chk("both_we",  32'(nwe), 32'd2);
    chk("both_mrd", mrd2, 32'hF00DCAFE);
    idle();
    chk("both_mem4", {16'b0, mem2[4]}, 32'h00005A5A);
    chk("both_mem5", {16'b0, mem2[5]}, 32'h0000A5A5);

    // Reset during WR_HI
    @(posedge clk); #1;
    sel = 0; w2 = 1; a2 = 32'd1040; d2 = 32'h11112222;
    repeat (3) @(posedge clk);
    #1;
    chk("rm_in_wrhi", {31'b0, we2}, 32'h0);
    rst = 1; w2 = 0;
    @(posedge clk); #2;
    chk("rm_we_n",  {31'b0, we2}, 32'h1);
    chk("rm_oe_n",  {31'b0, oe2}, 32'h1);
    chk("rm_dq_oe", {31'b0, dqoe2}, 32'h0);
    chk("rm_frz",   {31'b0, frz2}, 32'h0);
    chk("rm_mrd",   mrd2, 32'h0);
    chk("rm_addr",  {14'b0, ad2}, 32'h0);
    #1; rst = 0;
    @(posedge clk); #2;
    chk("rm_idle_frz", {31'b0, frz2}, 32'h0);

    // WAIT_CYCLES = 4 load from 1036 -> half addresses 6/7
    access(1, 1, 0, 32'd1036, 32'h0, nf, nwe, noe, ndq, lo_at);
    chk("w4_freeze", 32'(nf), 32'd9);
    chk("w4_oe_low", 32'(noe), 32'd8);
    chk("w4_lo_at",  32'(lo_at), 32'd5);
    chk("w4_mrd",    mrd4, 32'h7E7E3C3C);
    idle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_stage_sram_ctrl.md
# mem_stage_sram_ctrl

Memory-stage controller that consumes the EXE/MEM pipeline register outputs (`MEM_R_En`, `MEM_W_En`, `ALU_result`, `readdata`) and performs each 32-bit load or store on the board's external 16-bit asynchronous SRAM as two half-word accesses. While an access is in progress it drives `freeze` high, which holds the upstream pipeline registers. It returns the assembled load word to the MEM/WB register.

## Interface
- `WAIT_CYCLES`, default 2: cycles each half-word access occupies. Legal range is 2..15; the bench checks 2 and 4.
- `DATA_BASE`, default 1024: byte address of data-memory word 0.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  one clock; reset is synchronous and active-high.
- `MEM_R_En`  in  1  load request from the EXE/MEM register.
- `MEM_W_En`  in  1  store request from the EXE/MEM register.
- `ALU_result`  in  32  byte address of the access.
- `readdata`  in  32  store data (the rt value).
- `mem_read_data`  out  32  last completed load word. Registered.
- `freeze`  out  1  combinational; high means hold the PC, IF/ID, ID/EXE and EXE/MEM registers.
- `SRAM_ADDR`  out  18  SRAM half-word address.
- `SRAM_DQ_out`  out  16  write data. The top level tristates it using `SRAM_DQ_oe`.
- `SRAM_DQ_in`  in  16  read data from the pad.
- `SRAM_DQ_oe`  out  1  drive enable for the DQ pads.
- `SRAM_WE_N`, `SRAM_OE_N`  out  1  active-low strobes. `CE_N`, `UB_N` and `LB_N` are tied low at the top level.

## Operation
- **Address map.**
  - `eff = ALU_result - DATA_BASE`.
  - Low half address: `SRAM_ADDR = {eff[18:2], 1'b0}`. High half address: `{eff[18:2], 1'b1}`.
  - `eff[1:0]` is ignored; only word-aligned access is supported.
- **States:** IDLE, RD_LO, RD_HI, WR_LO, WR_HI, DONE. A counter `cnt` (4 bits) runs 0..WAIT_CYCLES-1 in each access state and clears on every state change.
- **IDLE**
  - If `MEM_W_En`, latch the address and `readdata`, then go to WR_LO. Write has priority when both enables are high.
  - Else if `MEM_R_En`, latch the address and go to RD_LO.
  - Else stay in IDLE.
- **RD_LO / RD_HI**
  - `SRAM_OE_N` = 0 and `SRAM_DQ_oe` = 0.
  - When `cnt == WAIT_CYCLES-1`: capture `SRAM_DQ_in` into the low (RD_LO) or high (RD_HI) 16 bits of `mem_read_data`, then advance to RD_HI or DONE.
- **WR_LO / WR_HI**
  - `SRAM_DQ_oe` = 1. `SRAM_DQ_out` = `wdata[15:0]` in WR_LO, `wdata[31:16]` in WR_HI.
  - `SRAM_WE_N` = 0 while `cnt < WAIT_CYCLES-1` and 1 on the last cycle, so address and data are held across the WE rising edge.
  - Then advance to WR_HI or DONE.
- **DONE**
  - `freeze` = 0 for exactly one cycle; the pipeline advances at this edge.
  - Enables are ignored in DONE, so the finished instruction is not reissued.
  - Always go to IDLE.
- **freeze** = `(state==IDLE && (MEM_R_En||MEM_W_En)) || state ∈ {RD_LO, RD_HI, WR_LO, WR_HI}`.
- **Outside the access states:** `SRAM_WE_N` = 1, `SRAM_OE_N` = 1, `SRAM_DQ_oe` = 0. `SRAM_ADDR` holds the latched address.
- A store never modifies `mem_read_data`.

## Timing
- **Reset values:** state IDLE, `cnt` 0, `mem_read_data` 0, latched address 0, latched data 0, `SRAM_ADDR` 0, `SRAM_DQ_out` 0, `SRAM_DQ_oe` 0, `SRAM_WE_N` 1, `SRAM_OE_N` 1.
- `freeze` is 0 after reset unless an enable is high during reset release.
- **Latency:** a request seen in IDLE at cycle T gives `freeze` high for cycles T .. T+2·WAIT_CYCLES and low at T+2·WAIT_CYCLES+1 (DONE). With the default this is 5 frozen cycles.
- A load's `mem_read_data` is valid from the DONE cycle onward.
- **Back-to-back** memory instructions: the second request is seen in IDLE at T+2·WAIT_CYCLES+2. There is no gap bubble other than the DONE cycle.
- **Reset mid-access:** next state is IDLE; `SRAM_WE_N`/`SRAM_OE_N` are high and `SRAM_DQ_oe` is 0 on the following cycle. The partial write is not completed and `mem_read_data` is cleared.
- Enables that drop during a frozen access have no effect; the latched request completes.

## Test plan
- **Store:** `MEM_W_En`=1, `ALU_result`=1028, `readdata`=0xDEADBEEF, default parameters.
  - SRAM half address 2 gets 0xBEEF and address 3 gets 0xDEAD.
  - `SRAM_WE_N` pulses low for 1 cycle per half.
  - `freeze` is high for exactly 5 cycles, then low for 1.
- **Load after store:** `MEM_R_En`=1 at 1028 with the SRAM model holding the above.
  - `mem_read_data` = 0xDEADBEEF in the DONE cycle.
  - `SRAM_OE_N` is low for 4 cycles; `SRAM_DQ_oe` stays 0 throughout.
- **Back-to-back:** store to 1024 immediately followed by a load from 1032.
  - Two separate 5-cycle freezes separated by a single DONE cycle.
  - The load address is not reissued in DONE.
- **Both enables:** `MEM_R_En`=`MEM_W_En`=1.
  - Treated as a write; `mem_read_data` is unchanged.
- **Reset mid-access:** assert `rst` during WR_HI.
  - Next cycle: state IDLE, `SRAM_WE_N`=1, `SRAM_DQ_oe`=0, `freeze`=0, `mem_read_data`=0.
- **Parameter check:** `WAIT_CYCLES`=4 with a load.
  - `freeze` is high for 9 cycles.
  - Data is captured on the 4th cycle of each half.
